// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: depth derivation, Gray conversion
// helpers and the write-side memory-clear sweep state encoding.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs convert correctly.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/fifo_wr_ptr.sv
// Write pointer register: binary count plus its registered Gray image, with
// increment enable and synchronous clear.
module fifo_wr_ptr
  import fifo_pkg::*;
#(
  parameter int PTR_W = 5
) (
  input  logic             wclk,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] wbin,
  output logic [PTR_W-1:0] wbin_nxt,
  output logic [PTR_W-1:0] wptr_gray
);

  assign wbin_nxt = wbin + PTR_W'(inc);

  always_ff @(posedge wclk) begin
    if (clr) begin
      wbin      <= '0;
      wptr_gray <= '0;
    end else begin
      wbin      <= wbin_nxt;
      wptr_gray <= PTR_W'(bin2gray(PTR_MAX_W'(wbin_nxt)));
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-domain controller: pointer, status flags, write count and
// an in-place memory-clear sweep. Build option: WR_OVERFLOW_STICKY_EN.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     wclk,
  input  logic                     hw_rst,
  input  logic                     sw_rst,
  input  logic                     mem_rst,
  input  logic                     write_enable,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [ADDRESS_WIDTH-1:0] afull_value,
  input  logic [ADDRESS_WIDTH:0]   rptr_gray_sync,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [ADDRESS_WIDTH:0]   wptr_gray,
  output logic                     wfull,
  output logic                     wr_almost_ful,
  output logic                     overflow,
  output logic [ADDRESS_WIDTH:0]   fifo_write_count,
  output logic [ADDRESS_WIDTH:0]   wr_level,
  output logic                     mem_clr_busy
);

  localparam int                       DEPTH     = fifo_depth(ADDRESS_WIDTH);
  localparam int                       PTR_W     = ADDRESS_WIDTH + 1;
  localparam logic [PTR_W-1:0]         LVL_FULL  = PTR_W'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  function automatic logic [PTR_W-1:0] sat_inc(input logic [PTR_W-1:0] v, input logic en);
    if (en && (v != '1)) begin
      return v + 1'b1;
    end
    return v;
  endfunction

  logic                     rst_any;
  logic                     accept;
  logic                     ovf_hit;
  logic [PTR_W-1:0]         wbin;
  logic [PTR_W-1:0]         wbin_nxt;
  logic [PTR_W-1:0]         rbin;
  logic [PTR_W-1:0]         lvl_next;
  logic [ADDRESS_WIDTH-1:0] sweep_cnt;
  sweep_state_t             state_q;
  sweep_state_t             state_d;

  assign rst_any      = hw_rst | sw_rst;
  assign mem_clr_busy = (state_q == CLEAR);
  assign accept       = write_enable & ~wfull & ~mem_clr_busy & ~rst_any;
  assign ovf_hit      = write_enable & (wfull | mem_clr_busy);
  assign rbin         = PTR_W'(gray2bin(PTR_MAX_W'(rptr_gray_sync)));
  assign lvl_next     = wbin_nxt - rbin;

  fifo_wr_ptr #(
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .wclk      (wclk),
    .clr       (rst_any),
    .inc       (accept),
    .wbin      (wbin),
    .wbin_nxt  (wbin_nxt),
    .wptr_gray (wptr_gray)
  );

  // Sweep next state and the memory write-port mux; the sweep owns the port.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = wbin[ADDRESS_WIDTH-1:0];
    mem_wdata = wdata;
    case (state_q)
      IDLE: begin
        mem_we = accept;
        if (mem_rst) state_d = CLEAR;
      end
      CLEAR: begin
        mem_we    = ~rst_any;
        mem_waddr = sweep_cnt;
        mem_wdata = '0;
        if (sweep_cnt == LAST_ADDR) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (rst_any) begin
      state_q   <= IDLE;
      sweep_cnt <= '0;
    end else begin
      state_q   <= state_d;
      sweep_cnt <= mem_clr_busy ? sweep_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge wclk) begin
    if (rst_any) begin
      wr_level         <= '0;
      wfull            <= 1'b0;
      wr_almost_ful    <= 1'b0;
      overflow         <= 1'b0;
      fifo_write_count <= '0;
    end else begin
      wr_level         <= lvl_next;
      wfull            <= (lvl_next == LVL_FULL);
      wr_almost_ful    <= (lvl_next >= {1'b0, afull_value});
      fifo_write_count <= sat_inc(fifo_write_count, accept);
`ifdef WR_OVERFLOW_STICKY_EN
      overflow         <= overflow | ovf_hit;
`else
      overflow         <= ovf_hit;
`endif
    end
  end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-domain controller for the async FIFO, parametrised in data width and depth. It owns the binary/Gray write pointer and computes the full, almost-full, overflow, count and level status against the read pointer, which arrives already synchronised into wclk. It drives the dual-port memory write port and adds an in-place memory-clear sweep, triggered by `mem_rst`, that the previous write side did not have. It sits between the write-side bench interface and the FIFO storage; `wptr_gray` goes to the read-domain synchroniser.

## Interface
- `DATA_WIDTH`, 32: payload width.
- `ADDRESS_WIDTH`, 4: memory address width; DEPTH = 2**ADDRESS_WIDTH.
- `wclk` in 1: write clock; sole clock of the block.
- `hw_rst` in 1: synchronous, active-high reset.
- `sw_rst` in 1: synchronous soft reset. Same effect as `hw_rst`.
- `mem_rst` in 1: start a memory-clear sweep.
- `write_enable` in 1: write request.
- `wdata` in DATA_WIDTH: write payload.
- `afull_value` in ADDRESS_WIDTH: almost-full threshold, in entries.
- `rptr_gray_sync` in ADDRESS_WIDTH+1: read pointer, Gray coded, already synchronised to wclk.
- `mem_we` out 1: memory write strobe.
- `mem_waddr` out ADDRESS_WIDTH: memory write address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `wptr_gray` out ADDRESS_WIDTH+1: registered Gray write pointer.
- `wfull` out 1: FIFO full.
- `wr_almost_ful` out 1: level has reached `afull_value`.
- `overflow` out 1: a write request was rejected.
- `fifo_write_count` out ADDRESS_WIDTH+1: accepted writes since reset; saturates at all-ones.
- `wr_level` out ADDRESS_WIDTH+1: current occupancy, 0..DEPTH.
- `mem_clr_busy` out 1: memory-clear sweep in progress.

## Operation
- **Pointer.** Internal `wbin` is ADDRESS_WIDTH+1 bits and wraps modulo 2**(ADDRESS_WIDTH+1). `wptr_gray` = bin2gray(`wbin`).
- **Accept rule.** accept = `write_enable` & !`wfull` & !`mem_clr_busy` & !`hw_rst` & !`sw_rst`. On accept, `wbin` increments.
- **Memory port.** Combinational.
  - IDLE: `mem_we` = accept, `mem_waddr` = `wbin`[ADDRESS_WIDTH-1:0], `mem_wdata` = `wdata`.
  - CLEAR: `mem_we` = 1, `mem_waddr` = sweep counter, `mem_wdata` = 0.
- **Level.** lvl_next = (`wbin` after this edge) − gray2bin(`rptr_gray_sync`), modulo 2**(ADDRESS_WIDTH+1). Registered outputs:
  - `wr_level` = lvl_next.
  - `wfull` = (lvl_next == DEPTH).
  - `wr_almost_ful` = (lvl_next ≥ zero-extended `afull_value`). With `afull_value` = 0 it is always set after the first post-reset cycle.
- **Overflow.** `overflow` pulses high for 1 cycle, on the edge after a cycle with `write_enable` & (`wfull` | `mem_clr_busy`).
- **Sweep FSM.** States IDLE and CLEAR.
  - IDLE → CLEAR on an edge where `mem_rst` = 1; sweep counter loads 0.
  - In CLEAR the counter increments every cycle. After address DEPTH−1 is written, the FSM returns to IDLE.
  - A sweep lasts exactly DEPTH cycles. `mem_clr_busy` = (state == CLEAR).
  - `mem_rst` asserted during CLEAR is ignored.
  - The sweep does not touch the pointers, level or count.
- **Priority.** `hw_rst` > `sw_rst` > sweep > write.
  - `sw_rst` during CLEAR aborts the sweep; the FSM goes to IDLE.
  - `mem_rst` and an accepted write in the same IDLE cycle: the write completes, and CLEAR starts the next cycle.
- **Reset values** (`hw_rst` or `sw_rst`):
  - `wbin`, `wptr_gray`, `wr_level`, `fifo_write_count` = 0.
  - `wfull`, `wr_almost_ful`, `overflow`, `mem_clr_busy` = 0; FSM in IDLE.
  - `mem_we` = 0 while either reset is high.

## Timing
- Accept-to-memory latency is 0: the memory captures on the same wclk edge that increments `wbin`.
- `wptr_gray`, `wr_level` and the flags are valid 1 cycle after the accepting edge.
- A change on `rptr_gray_sync` is reflected in `wfull`, `wr_almost_ful` and `wr_level` on the next edge.
- Full→not-full release latency is 1 wclk after the synchronised pointer moves.
- Back-to-back writes are accepted every cycle until `wfull`. At level DEPTH−1, a write sets `wfull` on that edge; a write requested in the next cycle is rejected and raises `overflow`.
- `wptr_gray` changes exactly 1 bit per increment, including the wrap from 2**(ADDRESS_WIDTH+1)−1 to 0.

## Configuration
- Macro: `WR_OVERFLOW_STICKY_EN`.
- **Defined:** `overflow` latches high on the first rejected write and holds until `hw_rst` or `sw_rst`.
- **Undefined:** `overflow` is the 1-cycle pulse described above.

## Structure
- Package `fifo_pkg` holds:
  - the DEPTH derivation;
  - the `bin2gray` and `gray2bin` functions;
  - the sweep-FSM state enum (IDLE, CLEAR).
- One sub-module, `fifo_wr_ptr`, holds the binary/Gray pointer register with its increment enable and synchronous clear.
- The flags, count, sweep FSM and memory mux stay in `fifo_wr_ctrl`.

## Test plan
- **Fill.** ADDRESS_WIDTH=4, read pointer held at 0, 16 consecutive writes → `wfull`=1 after the 16th, `wr_level`=16, `wptr_gray`=0x18. A 17th write → `overflow` pulses, `mem_we`=0.
- **Almost full.** `afull_value`=12 → `wr_almost_ful` rises on the edge after the 12th write, and falls 1 cycle after `rptr_gray_sync` advances to gray(1).
- **Wrap.** Alternate writes with read-pointer advances through 40 writes → `wbin` wraps past 31, `wr_level` stays at most 1, `fifo_write_count` saturates at 31.
- **Sweep.** `mem_rst` for 1 cycle → `mem_clr_busy` high for 16 cycles, addresses 0..15 written with 0. A write during the sweep is rejected with `overflow`; pointers are unchanged.
- **Reset mid-operation.** `sw_rst` asserted in sweep cycle 5 → FSM returns to IDLE and all outputs are 0 on the next edge. `hw_rst` while full → `wfull`=0, `wr_level`=0.
- **Sticky.** With `WR_OVERFLOW_STICKY_EN` defined, a rejected write → `overflow` stays 1 across 20 cycles and clears only on `sw_rst`.
